axil_reg_arbiter: RTL and testbench
===================================

Name: axil_reg_arbiter

Overview:
- Shares one AXI4-Lite master port between two local requesters (host command path and SABER engine sequencer) that access the 4-register AXIslave bank.
- Round-robin grant, one transaction in flight.
- Converts a simple valid/ready request plus a one-cycle response pulse into AXI4-Lite AW/W/B or AR/R sequences.

Parameters:
ADDR_WIDTH, 4, byte address width (4 x 32-bit registers, 0x0-0xC)
DATA_WIDTH, 32, data width; only 32 is supported
TIMEOUT_CYCLES, 256, watchdog limit; used only when the optional feature is compiled in

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
req_valid  in  2  per-requester request strobe, held until accepted
req_ready  out  2  one-hot one-cycle accept pulse
req_we  in  2  per-requester 1=write, 0=read
req_addr  in  2*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  2*DATA_WIDTH  packed write data
rsp_valid  out  2  one-hot one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  1 if BRESP/RRESP != OKAY, valid with rsp_valid
M_AXI_AWADDR/AWPROT/AWVALID  out  ADDR_WIDTH/3/1  write address channel; AWPROT=3'b000
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB/WVALID  out  32/4/1  write data channel; WSTRB=4'hF
M_AXI_WREADY  in  1
M_AXI_BRESP/BVALID  in  2/1  write response
M_AXI_BREADY  out  1
M_AXI_ARADDR/ARPROT/ARVALID  out  ADDR_WIDTH/3/1  read address channel; ARPROT=3'b000
M_AXI_ARREADY  in  1
M_AXI_RDATA/RRESP/RVALID  in  32/2/1  read data channel
M_AXI_RREADY  out  1

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = 1 (requester 0 wins first tie).
- FSM: IDLE -> WR_ADDR (write) or RD_ADDR (read) -> WR_RESP or RD_DATA -> DONE -> IDLE.
- IDLE:
  - If any req_valid, grant one; on a tie grant the requester not granted last.
  - Pulse req_ready[g] for that cycle and latch we/addr/wdata and g.
  - No grant occurs outside IDLE, so a request is never accepted while one is in flight.
- WR_ADDR:
  - AWVALID and WVALID rise together on the first cycle after the grant.
  - Each drops independently on its own handshake and never drops before it.
  - Leave WR_ADDR when both handshakes have completed, in either order or the same cycle.
- WR_RESP: BREADY=1; on BVALID capture BRESP and go to DONE.
- RD_ADDR: ARVALID held until ARREADY.
- RD_DATA: RREADY=1; on RVALID capture RDATA and RRESP and go to DONE.
- DONE:
  - rsp_valid[g]=1 for exactly one cycle.
  - rsp_rdata = captured data for reads, 0 for writes.
  - rsp_err = (resp != 2'b00).
  - Update rr pointer to g.
- Minimum latency, zero-wait slave: write accept at t0 gives rsp at t3; read likewise at t3. Back-to-back throughput is one transaction per 4 cycles.
- A request deasserted before acceptance is dropped silently.
- ARESETN low in any state: all VALID/READY/rsp outputs clear immediately and the in-flight transaction is discarded with no rsp pulse.

Optional Feature:
- AXIL_ARB_TIMEOUT_EN defined:
  - A counter runs in every wait state and clears on each state change.
  - When it reaches TIMEOUT_CYCLES, drop all VALIDs and go to DONE with rsp_err=1 and rsp_rdata=0.
  - A late BVALID/RVALID arriving in IDLE is consumed (BREADY/RREADY=1 in IDLE) and ignored.
- Undefined: no counter; wait states wait indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package axil_arb_pkg: state enum, resp constants (OKAY=2'b00, SLVERR=2'b10), WSTRB_ALL=4'hF, PROT_DEFAULT=3'b000.
- Sub-module rr_arb2: 2-way round-robin grant from the request vector and last-grant pointer; purely combinational; pointer held in the parent.

Test Plan:
- Requester 0 writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then reads all four -> rdata 1..4, rsp_err=0, rsp_valid only on bit 0.
- Both req_valid asserted continuously, requester 0 writing 0xA and requester 1 writing 0xB to 0x0 -> grants alternate 0,1,0,1; final read of 0x0 matches the last granted writer.
- Slave delays AWREADY 3 cycles and WREADY 0 cycles -> WVALID drops after 1 cycle, AWVALID after 4; a single BREADY phase; one rsp pulse.
- Slave returns RRESP=2'b10 on a read of 0x8 -> rsp_err=1 and rsp_rdata equals RDATA.
- ARESETN pulsed low while in WR_RESP -> no rsp_valid; next request is accepted starting from IDLE with requester 0 priority.
- AXIL_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and ARREADY held low -> rsp_err=1 and rsp_rdata=0, ARVALID drops 16 cycles after rising.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared state encoding and AXI4-Lite constants for axil_reg_arbiter
package axil_arb_pkg;
    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [3:0] WSTRB_ALL    = 4'hF;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axil_reg_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant
//   req  : request vector
//   last : index of the requester granted most recently (pointer lives in the parent)
//   gnt  : one-hot grant, zero when nobody requests
//   idx  : index of the granted requester
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       idx
);
    assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
    assign idx = gnt[1];
endmodule

// File: rtl/axil_reg_arbiter.sv
// axil_reg_arbiter: shares one AXI4-Lite master between two valid/ready requesters
//   ACLK/ARESETN        : clock, asynchronous active-low reset
//   req_*               : per-requester request (valid held until req_ready pulse)
//   rsp_*               : one-hot completion pulse with read data and error flag
//   M_AXI_*             : AXI4-Lite master port, one transaction in flight
//   AXIL_ARB_TIMEOUT_EN : when defined, wait states abort after TIMEOUT_CYCLES
//                         with rsp_err=1, and late B/R beats are drained in IDLE
module axil_reg_arbiter
    import axil_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);
    if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("axil_reg_arbiter: DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
    end

    state_t                  state;
    logic                    last, g, gi, hs, to_hit, aw_ok, w_ok;
    logic [1:0]              gnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam logic IDLE_RDY = 1'b1;
`else
    localparam logic IDLE_RDY = 1'b0;
`endif

    rr_arb2 u_arb (.req(req_valid), .last(last), .gnt(gnt), .idx(gi));

    // Accept is combinational so the grant lands in the same IDLE cycle.
    assign req_ready    = (ARESETN && state == IDLE) ? gnt : 2'b00;
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = WSTRB_ALL;
    assign M_AXI_AWPROT = PROT_DEFAULT;
    assign M_AXI_ARPROT = PROT_DEFAULT;

    // A channel counts as done once its VALID has dropped or is handshaking now.
    assign aw_ok = !M_AXI_AWVALID || M_AXI_AWREADY;
    assign w_ok  = !M_AXI_WVALID || M_AXI_WREADY;

    always_comb
        hs = (state == WR_ADDR) ? aw_ok && w_ok :
             (state == WR_RESP) ? M_AXI_BVALID :
             (state == RD_ADDR) ? M_AXI_ARREADY :
             (state == RD_DATA) ? M_AXI_RVALID : 1'b0;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic          wait_st;
    assign wait_st = state inside {WR_ADDR, WR_RESP, RD_ADDR, RD_DATA};
    // Counting from 0 on the first wait cycle, hitting T-1 means T cycles waited.
    assign to_hit  = wait_st && !hs && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) cnt <= '0;
        else cnt <= (wait_st && !hs && !to_hit) ? cnt + 1'b1 : '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            last          <= 1'b1;
            g             <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 2'b00;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        g            <= gi;
                        addr_q       <= gi ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                        wdata_q      <= gi ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                        M_AXI_BREADY <= 1'b0;
                        M_AXI_RREADY <= 1'b0;
                        if (req_we[gi]) begin
                            state         <= WR_ADDR;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                        end else begin
                            state         <= RD_ADDR;
                            M_AXI_ARVALID <= 1'b1;
                        end
                    end else begin
                        M_AXI_BREADY <= IDLE_RDY;
                        M_AXI_RREADY <= IDLE_RDY;
                    end
                end
                WR_ADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    if (hs) begin
                        state        <= WR_RESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (hs) begin
                        state        <= DONE;
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= {g, !g};
                        rsp_rdata    <= '0;
                        rsp_err      <= M_AXI_BRESP != RESP_OKAY;
                    end
                end
                RD_ADDR: begin
                    if (hs) begin
                        state         <= RD_DATA;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (hs) begin
                        state        <= DONE;
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= {g, !g};
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_err      <= M_AXI_RRESP != RESP_OKAY;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    last         <= g;
                    rsp_valid    <= 2'b00;
                    rsp_rdata    <= '0;
                    rsp_err      <= 1'b0;
                    M_AXI_BREADY <= IDLE_RDY;
                    M_AXI_RREADY <= IDLE_RDY;
                end
                default: state <= IDLE;
            endcase
            // Watchdog abort overrides whatever the wait state would have done.
            if (to_hit) begin
                state         <= DONE;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                rsp_valid     <= {g, !g};
                rsp_rdata     <= '0;
                rsp_err       <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axil_reg_arbiter.sv
// tb_axil_reg_arbiter: scoreboard bench for axil_reg_arbiter with a behavioural AXI4-Lite slave
module tb_axil_reg_arbiter;
    logic        ACLK, ARESETN;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, wdata, rdata;
    logic        rsp_err;
    logic [3:0]  awaddr, araddr, wstrb;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_reg_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int ncmp = 0, nfail = 0, cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural slave: 4 registers, configurable AW/AR delays, B/AR stalls, error address.
    logic [31:0] mem [4];
    int          aw_dly = 0, ar_dly = 0, aw_w, ar_w;
    bit          b_block = 0, ar_block = 0, err_en = 0;
    logic [3:0]  err_addr = 4'h0, s_awaddr, wa;
    logic [31:0] s_wdata, wd;
    logic        has_aw, has_w;

    assign awready = awvalid && !has_aw && aw_w >= aw_dly;
    assign wready  = wvalid && !has_w;
    assign arready = arvalid && !ar_block && ar_w >= ar_dly && !rvalid;
    assign wa      = has_aw ? s_awaddr : awaddr;
    assign wd      = has_w ? s_wdata : wdata;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_w <= 0; ar_w <= 0; has_aw <= 0; has_w <= 0;
            bvalid <= 0; bresp <= 2'b00; rvalid <= 0; rresp <= 2'b00; rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0;
        end else begin
            aw_w <= (awvalid && !awready) ? aw_w + 1 : 0;
            ar_w <= (arvalid && !arready) ? ar_w + 1 : 0;
            if (awvalid && awready) begin has_aw <= 1; s_awaddr <= awaddr; end
            if (wvalid && wready) begin has_w <= 1; s_wdata <= wdata; end
            if ((has_aw || (awvalid && awready)) && (has_w || (wvalid && wready)) && !b_block && !bvalid) begin
                mem[wa[3:2]] <= wd;
                bvalid <= 1; bresp <= 2'b00; has_aw <= 0; has_w <= 0;
            end
            if (bvalid && bready) bvalid <= 0;
            if (arvalid && arready) begin
                rvalid <= 1;
                rdata  <= mem[araddr[3:2]];
                rresp  <= (err_en && araddr == err_addr) ? 2'b10 : 2'b00;
            end
            if (rvalid && rready) rvalid <= 0;
        end
    end

    // Scoreboard: expectation pushed at accept, popped at the response pulse.
    typedef struct { logic [1:0] id; logic [31:0] rd; logic er; int cyc; } sb_t;
    sb_t         sb[$], e;
    int          grants[$], accs[$];
    logic [31:0] exp_rd[2];
    logic        exp_er[2];
    logic [1:0]  exp_g;
    logic        model_last = 1'b1;
    int          last_lat = 0, nrsp = 0, ngrant = 0, aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0;

    always @(negedge ACLK) begin
        if (ARESETN) begin
            aw_hi += int'(awvalid);
            w_hi  += int'(wvalid);
            ar_hi += int'(arvalid);
            b_hs  += int'(bvalid && bready);
            if (req_ready != 2'b00) begin
                exp_g = (req_valid == 2'b11) ? (model_last ? 2'b01 : 2'b10) : req_valid;
                check("grant", req_ready, exp_g);
                sb.push_back('{req_ready, exp_rd[req_ready[1]], exp_er[req_ready[1]], cyc});
                grants.push_back(int'(req_ready[1]));
                accs.push_back(cyc);
                ngrant++;
            end
            if (rsp_valid != 2'b00) begin
                nrsp++;
                if (sb.size() == 0) check("unexpected rsp_valid", rsp_valid, 2'b00);
                else begin
                    e = sb.pop_front();
                    check("rsp_valid", rsp_valid, e.id);
                    check("rsp_rdata", rsp_rdata, e.rd);
                    check("rsp_err", rsp_err, e.er);
                    last_lat = cyc - e.cyc;
                    model_last = rsp_valid[1];
                end
            end
        end
    end

    task automatic issue(input int r, input logic we, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee);
        int n = 0;
        @(posedge ACLK); #1;
        exp_rd[r] = er; exp_er[r] = ee;
        req_we[r] = we;
        req_addr[r*4 +: 4] = a;
        req_wdata[r*32 +: 32] = d;
        req_valid[r] = 1'b1;
        do begin @(negedge ACLK); n++; end while (!req_ready[r] && n < 100);
        check("accept", req_ready[r], 1'b1);
        @(posedge ACLK); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin @(negedge ACLK); n++; end
        if (sb.size() != 0) check(name, sb.size(), 0);
        @(negedge ACLK);
    endtask

    typedef struct { int r; logic we; logic [3:0] addr; logic [31:0] wdata; logic [31:0] rd; logic er; } vec_t;
    vec_t tbl[8];

    initial begin
        int n, g0, r0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g0, r0;
        for (int i = 0; i < 4; i++) begin
            tbl[i]   = '{0, 1'b1, 4'(i * 4), 32'(i + 1), 32'h0, 1'b0};
            tbl[i+4] = '{0, 1'b0, 4'(i * 4), 32'h0, 32'(i + 1), 1'b0};
        end
        ARESETN = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        exp_rd[0] = 0; exp_rd[1] = 0; exp_er[0] = 0; exp_er[1] = 0;
        repeat (2) @(negedge ACLK);
        check("reset outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, awvalid, wvalid, bready, arvalid, rready, awaddr, wdata}, '0);
        check("wstrb/prot", {wstrb, awprot, arprot}, {4'hF, 6'h0});
        @(posedge ACLK); #1 ARESETN = 1;

        // Requester 0 fills the bank then reads it back, zero-wait slave.
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].r, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].er);
            wait_done("table rsp timeout");
            check("latency", last_lat, 3);
        end

        // AWREADY delayed 3 cycles, WREADY immediate.
        aw_dly = 3; aw_hi = 0; w_hi = 0; b_hs = 0; r0 = nrsp;
        issue(1, 1'b1, 4'h4, 32'h77, 32'h0, 1'b0);
        wait_done("aw delay rsp timeout");
        check("awvalid cycles", aw_hi, 4);
        check("wvalid cycles", w_hi, 1);
        check("b handshakes", b_hs, 1);
        check("rsp pulses", nrsp - r0, 1);
        check("aw delay latency", last_lat, 6);
        aw_dly = 0;

        // Slave error response on a read of 0x8.
        err_en = 1; err_addr = 4'h8;
        issue(0, 1'b0, 4'h8, 32'h0, 32'h3, 1'b1);
        wait_done("err rsp timeout");
        err_en = 0;

        // Reset while waiting for BVALID: no response, outputs clear at once.
        b_block = 1;
        issue(1, 1'b1, 4'hC, 32'h55, 32'h0, 1'b0);
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bready && n < 20);
        check("reached WR_RESP", bready, 1'b1);
        @(negedge ACLK);
        ARESETN = 0;
        #1 check("async clear", {req_ready, rsp_valid, rsp_err, awvalid, wvalid, bready, arvalid, rready}, '0);
        sb.delete(); model_last = 1'b1; r0 = nrsp;
        repeat (2) @(negedge ACLK);
        b_block = 0;
        @(posedge ACLK); #1 ARESETN = 1;
        repeat (6) @(negedge ACLK);
        check("no rsp after reset", nrsp - r0, 0);

        // Both requesters write 0x0 continuously: grants alternate from requester 0.
        @(posedge ACLK); #1;
        g0 = ngrant;
        exp_rd = '{32'h0, 32'h0}; exp_er = '{1'b0, 1'b0};
        req_we = 2'b11; req_addr = 8'h00; req_wdata = {32'hB, 32'hA}; req_valid = 2'b11;
        n = 0;
        while (ngrant < g0 + 4 && n < 100) begin @(negedge ACLK); n++; end
        check("contention grants", ngrant - g0, 4);
        @(posedge ACLK); #1 req_valid = 2'b00;
        wait_done("contention rsp timeout");
        if (grants.size() >= 4) begin
            check("grant order", {grants[g0], grants[g0+1], grants[g0+2], grants[g0+3]}, {32'd0, 32'd1, 32'd0, 32'd1});
            for (int k = 0; k < 3; k++) check("throughput", accs[g0+k+1] - accs[g0+k], 4);
        end
        issue(0, 1'b0, 4'h0, 32'h0, 32'hB, 1'b0);
        wait_done("final read timeout");

`ifdef AXIL_ARB_TIMEOUT_EN
        // ARREADY never comes: watchdog aborts after 16 wait cycles.
        ar_block = 1; ar_hi = 0;
        issue(0, 1'b0, 4'h4, 32'h0, 32'h0, 1'b1);
        wait_done("timeout rsp missing");
        check("arvalid cycles before timeout", ar_hi, 16);
        ar_block = 0;
`endif

        repeat (3) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
